dot_scan_capture: RTL and testbench
===================================

# dot_scan_capture

Receive-side counterpart of the snake game's 8x8 dot-matrix scan output. Samples the multiplexed `row`/`col` lines on each scan tick and rebuilds the displayed image row by row. Publishes a complete 64-bit frame with a one-cycle strobe once all eight rows of a scan have been captured stably. Used as a board-level display monitor and as the scoreboard front end in game-level benches. Flags incomplete, multi-row and stuck scans.

## Interface
- `ROW_ACTIVE_LOW`, default 0: the selected row line is driven 0 when 1, and 1 when 0.
- `COL_ACTIVE_LOW`, default 1: a lit column is driven 0 when 1, and 1 when 0.
- `STABLE_TICKS`, default 2 (range 1–15): consecutive identical samples needed before a row's column data is latched.
- `TIMEOUT_TICKS`, default 64 (range 2–255): ticks without a row-index change that count as a stuck scan.
- `clk` in 1: single clock, the same system clock the game uses.
- `rst` in 1: synchronous, active-high reset.
- `sample_en` in 1: scan tick, one `clk` wide (the 10 kHz divided tick). All sampling is qualified by this input.
- `dot_row` in 8: row select lines, raw polarity.
- `dot_col` in 8: column lines, raw polarity.
- `frame` out 64: last published image; `frame[8*r+c]` = row r, column c is lit (1 = lit).
- `frame_valid` out 1: one-`clk` strobe; `frame` was updated this cycle.
- `row_seen` out 8: rows latched so far in the frame under construction.
- `scan_err` out 1: one-`clk` strobe on a detected fault.
- `err_code` out 2: cause of the last fault, held until the next fault or reset. 0 = none, 1 = INCOMPLETE, 2 = MULTI_ROW, 3 = STUCK.

## Operation
- Normalisation: `r = dot_row ^ {8{ROW_ACTIVE_LOW}}` and `c = dot_col ^ {8{COL_ACTIVE_LOW}}`, so both are active-high.
- Row classification: `r` is one-hot (index 0–7), zero (blank gap) or multi-hot.
- State ALIGN (after reset or an error):
  - Ignore samples until `r` is one-hot with index 0.
  - Then go to CAPTURE, with `row_seen` = 0 and the stable counter starting at this sample.
- State CAPTURE, on each `sample_en`:
  - **Blank**: ignored. The stable counter holds and `prev_idx` is retained.
  - **Multi-hot**: `scan_err` strobes with `err_code` = 2. `row_seen` clears, shadow data is discarded, and the state returns to ALIGN.
  - **One-hot, same index and same `c` as the previous accepted sample**: the stable counter increments, saturating. When it reaches `STABLE_TICKS`, `shadow[idx] <= c` and `row_seen[idx] <= 1`. A later change of `c` on the same row re-arms the counter, and the shadow row is overwritten once stable again.
  - **One-hot, different index**: the stable counter restarts at 1 and the timeout counter clears.
    - If `STABLE_TICKS` = 1, the new row is latched on this sample.
    - Wrap (`prev_idx` = 7, new idx = 0): if `row_seen` is all ones, `frame <= shadow` and `frame_valid` strobes. Otherwise `scan_err` strobes with `err_code` = 1 and no publish. In both cases `row_seen` clears before row 0 is counted.
    - Non-sequential index jumps are legal: any order is accepted, and only completeness at wrap matters.
- Timeout: in CAPTURE, a counter increments on each `sample_en` without an index change.
  - On reaching `TIMEOUT_TICKS`: `scan_err` strobes with `err_code` = 3, the state returns to ALIGN and `row_seen` clears.
  - Blank samples also count toward the timeout.
- Simultaneous events:
  - Multi-hot takes priority over everything else.
  - An index change (including wrap) clears the timeout in the same tick, so STUCK and a publish never occur together.
  - `frame_valid` and `scan_err` are mutually exclusive.
- Samples while `sample_en` = 0 are ignored entirely.

## Timing
- Registered inputs are not required; `dot_row`/`dot_col` are synchronous to `clk`.
- Publish latency: `frame` and `frame_valid` update on the `clk` edge that consumes the wrap `sample_en`, so they are visible the cycle after it.
- `frame` holds between publishes.
- Reset values:
  - `frame` = 0, `frame_valid` = 0, `scan_err` = 0, `err_code` = 0, `row_seen` = 0.
  - Shadow = 0, counters = 0, state = ALIGN.
- `rst` mid-frame discards the shadow and partial progress on the next edge. The first publish after reset needs a full 0..7 scan followed by a wrap to 0.

## Structure
- Package `dot_scan_pkg`: state enum (ALIGN, CAPTURE) and the `err_code` constants ERR_NONE, ERR_INCOMPLETE, ERR_MULTI_ROW, ERR_STUCK.
- Sub-module `onehot8_decode`: 8-bit input to 3-bit index plus flags `is_onehot`, `is_zero` and `is_multi`. Purely combinational.

## Test plan
- **Clean scan**: defaults (`STABLE_TICKS` = 2), rows 0–7 each held 2 ticks with col active-low `~8'h81`, then row 0 again. Required: `frame_valid` once, and `frame` = 64'h8181818181818181.
- **Incomplete scan**: scan 0–7 with row 5 held only 1 tick, then wrap. Required: `scan_err` with `err_code` = 1, `frame` unchanged, and `row_seen` = 0 after the wrap.
- **Multi-row**: `dot_row` = 8'h03 during CAPTURE. Required: `scan_err` with `err_code` = 2, then ALIGN. The next clean scan publishes correctly.
- **Stuck**: row 3 held for 64 ticks. Required: `scan_err` with `err_code` = 3 on the 64th tick, and no `frame_valid`.
- **Reset mid-frame**: `rst` after rows 0–4 have been captured. Required: all outputs at reset values next cycle, and the partial rows are not published at a later wrap.
- **Gaps and gating**: blank rows between each row plus `sample_en` low for 10 cycles mid-row. Required: still publishes the correct frame, with the blanks counted toward the timeout only.

Source files
------------

// File: rtl/dot_scan_pkg.sv
// Shared types and fault codes for the dot-matrix scan capture block.
package dot_scan_pkg;

  typedef enum logic {
    ALIGN   = 1'b0,
    CAPTURE = 1'b1
  } state_e;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE       = 2'd0;
  localparam err_code_t ERR_INCOMPLETE = 2'd1;
  localparam err_code_t ERR_MULTI_ROW  = 2'd2;
  localparam err_code_t ERR_STUCK      = 2'd3;

endpackage

// File: rtl/onehot8_decode.sv
// Classifies an 8-bit select vector as zero, one-hot or multi-hot and
// reports the index of the set bit.
module onehot8_decode (
  input  logic [7:0] vec_i,
  output logic [2:0] idx_o,
  output logic       is_onehot_o,
  output logic       is_zero_o,
  output logic       is_multi_o
);

  logic [3:0] ones;

  always_comb begin
    ones  = '0;
    idx_o = '0;
    for (int i = 0; i < 8; i++) begin
      if (vec_i[i]) begin
        ones  = ones + 4'd1;
        idx_o = 3'(i);
      end
    end
  end

  assign is_zero_o   = (ones == 4'd0);
  assign is_onehot_o = (ones == 4'd1);
  assign is_multi_o  = (ones > 4'd1);

endmodule

// File: rtl/dot_scan_capture.sv
// Rebuilds the 8x8 dot-matrix image from the multiplexed row/col scan lines
// and publishes complete, stable frames; flags incomplete, multi-row and stuck scans.
module dot_scan_capture
  import dot_scan_pkg::*;
#(
  parameter bit          ROW_ACTIVE_LOW = 1'b0,
  parameter bit          COL_ACTIVE_LOW = 1'b1,
  parameter int unsigned STABLE_TICKS   = 2,
  parameter int unsigned TIMEOUT_TICKS  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_en,
  input  logic [7:0]  dot_row,
  input  logic [7:0]  dot_col,
  output logic [63:0] frame,
  output logic        frame_valid,
  output logic [7:0]  row_seen,
  output logic        scan_err,
  output logic [1:0]  err_code
);

  localparam logic [3:0] STABLE_MAX  = 4'(STABLE_TICKS);
  localparam logic [7:0] TIMEOUT_MAX = 8'(TIMEOUT_TICKS);

  logic [7:0] r, c;
  logic [2:0] idx;
  logic       is_onehot, is_zero, is_multi;

  assign r = dot_row ^ {8{ROW_ACTIVE_LOW}};
  assign c = dot_col ^ {8{COL_ACTIVE_LOW}};

  onehot8_decode u_decode (
    .vec_i       (r),
    .idx_o       (idx),
    .is_onehot_o (is_onehot),
    .is_zero_o   (is_zero),
    .is_multi_o  (is_multi)
  );

  state_e          state_q, state_d;
  logic [7:0][7:0] shadow_q, shadow_d;
  logic [7:0]      row_seen_q, row_seen_d;
  logic [2:0]      prev_idx_q, prev_idx_d;
  logic [7:0]      prev_c_q, prev_c_d;
  logic [3:0]      stable_q, stable_d;
  logic [7:0]      timer_q, timer_d;
  logic [63:0]     frame_q, frame_d;
  logic            frame_valid_q, frame_valid_d;
  logic            scan_err_q, scan_err_d;
  err_code_t       err_code_q, err_code_d;
  logic            fault;
  err_code_t       fault_code;

  always_comb begin
    // NOTE: every next-state value starts from its register so no path infers a latch.
    state_d       = state_q;
    shadow_d      = shadow_q;
    row_seen_d    = row_seen_q;
    prev_idx_d    = prev_idx_q;
    prev_c_d      = prev_c_q;
    stable_d      = stable_q;
    timer_d       = timer_q;
    frame_d       = frame_q;
    frame_valid_d = 1'b0;
    scan_err_d    = 1'b0;
    err_code_d    = err_code_q;
    fault         = 1'b0;
    fault_code    = ERR_NONE;

    if (sample_en) begin
      case (state_q)
        ALIGN: begin
          if (is_onehot && idx == 3'd0) begin
            state_d    = CAPTURE;
            row_seen_d = '0;
            prev_idx_d = 3'd0;
            prev_c_d   = c;
            stable_d   = 4'd1;
            timer_d    = 8'd1;
            if (STABLE_MAX == 4'd1) begin
              shadow_d[0]   = c;
              row_seen_d[0] = 1'b1;
            end
          end
        end
        CAPTURE: begin
          if (is_multi) begin
            fault      = 1'b1;
            fault_code = ERR_MULTI_ROW;
          end else if (is_onehot && idx != prev_idx_q) begin
            // The entry sample counts as the first tick on the new row.
            prev_idx_d = idx;
            prev_c_d   = c;
            stable_d   = 4'd1;
            timer_d    = 8'd1;
            if (prev_idx_q == 3'd7 && idx == 3'd0) begin
              if (&row_seen_q) begin
                frame_d       = shadow_q;
                frame_valid_d = 1'b1;
              end else begin
                scan_err_d = 1'b1;
                err_code_d = ERR_INCOMPLETE;
              end
              row_seen_d = '0;
            end
            if (STABLE_MAX == 4'd1) begin
              shadow_d[idx]   = c;
              row_seen_d[idx] = 1'b1;
            end
          end else begin
            if (!is_zero) begin
              if (c != prev_c_q) begin
                prev_c_d = c;
                stable_d = 4'd1;
              end else if (stable_q < STABLE_MAX) begin
                stable_d = stable_q + 4'd1;
              end
              if (stable_d == STABLE_MAX) begin
                shadow_d[idx]   = c;
                row_seen_d[idx] = 1'b1;
              end
            end
            timer_d = timer_q + 8'd1;
            if (timer_d == TIMEOUT_MAX) begin
              fault      = 1'b1;
              fault_code = ERR_STUCK;
            end
          end
        end
      endcase
    end

    if (fault) begin
      state_d    = ALIGN;
      shadow_d   = '0;
      row_seen_d = '0;
      stable_d   = '0;
      timer_d    = '0;
      scan_err_d = 1'b1;
      err_code_d = fault_code;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q       <= ALIGN;
      // NOTE: the shadow image is reset too, so a fresh scan never sees stale rows.
      shadow_q      <= '0;
      row_seen_q    <= '0;
      prev_idx_q    <= '0;
      prev_c_q      <= '0;
      stable_q      <= '0;
      timer_q       <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      scan_err_q    <= 1'b0;
      err_code_q    <= ERR_NONE;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      row_seen_q    <= row_seen_d;
      prev_idx_q    <= prev_idx_d;
      prev_c_q      <= prev_c_d;
      stable_q      <= stable_d;
      timer_q       <= timer_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      scan_err_q    <= scan_err_d;
      err_code_q    <= err_code_d;
    end
  end

  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;
  assign row_seen    = row_seen_q;
  assign scan_err    = scan_err_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_dot_scan_capture.sv
// Self-checking bench for dot_scan_capture: directed vector table, hand-written
// corner sequences and randomized scans against a sample-history reference model.
module tb_dot_scan_capture;

  localparam bit ROW_AL  = 1'b0;
  localparam bit COL_AL  = 1'b1;
  localparam int STABLE  = 2;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_en;
  logic [7:0]  dot_row, dot_col;
  logic [63:0] frame;
  logic        frame_valid;
  logic [7:0]  row_seen;
  logic        scan_err;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  dot_scan_capture #(
    .ROW_ACTIVE_LOW (ROW_AL),
    .COL_ACTIVE_LOW (COL_AL),
    .STABLE_TICKS   (STABLE),
    .TIMEOUT_TICKS  (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_en   (sample_en),
    .dot_row     (dot_row),
    .dot_col     (dot_col),
    .frame       (frame),
    .frame_valid (frame_valid),
    .row_seen    (row_seen),
    .scan_err    (scan_err),
    .err_code    (err_code)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: remembers every column sample taken on the current row
  // and decides latching by looking back over that history.
  bit          m_in_scan;
  logic [7:0]  m_img [8];
  logic [7:0]  m_seen;
  int          m_row;
  int          m_age;
  logic [7:0]  m_hist [$];
  logic [63:0] m_frame;
  logic [1:0]  m_code;
  bit          m_fv, m_err;

  task automatic m_reset();
    m_in_scan = 0;
    foreach (m_img[i]) m_img[i] = '0;
    m_seen = '0; m_row = 0; m_age = 0; m_hist = {};
    m_frame = '0; m_code = 2'd0; m_fv = 0; m_err = 0;
  endtask

  task automatic m_fault(input logic [1:0] code);
    m_in_scan = 0;
    foreach (m_img[i]) m_img[i] = '0;
    m_seen = '0;
    m_err  = 1;
    m_code = code;
  endtask

  task automatic m_try_latch();
    bit same;
    same = 1;
    if (m_hist.size() < STABLE) return;
    for (int i = 0; i < STABLE; i++)
      if (m_hist[m_hist.size() - 1 - i] != m_hist[m_hist.size() - 1]) same = 0;
    if (same) begin
      m_img[m_row]  = m_hist[m_hist.size() - 1];
      m_seen[m_row] = 1'b1;
    end
  endtask

  task automatic m_step(input bit en, input logic [7:0] rr, input logic [7:0] cc);
    int k;
    m_fv = 0; m_err = 0;
    if (!en) return;
    if (!m_in_scan) begin
      if (rr == 8'h01) begin
        m_in_scan = 1; m_seen = '0; m_row = 0; m_hist = {cc}; m_age = 1;
        m_try_latch();
      end
      return;
    end
    if ($countones(rr) > 1) begin
      m_fault(2'd2);
      return;
    end
    if ($countones(rr) == 1) begin
      k = 0;
      for (int i = 0; i < 8; i++) if (rr[i]) k = i;
      if (k != m_row) begin
        if (m_row == 7 && k == 0) begin
          if (m_seen == 8'hFF) begin
            for (int i = 0; i < 8; i++) m_frame[8*i +: 8] = m_img[i];
            m_fv = 1;
          end else begin
            m_err = 1; m_code = 2'd1;
          end
          m_seen = '0;
        end
        m_row = k; m_hist = {cc}; m_age = 1;
        m_try_latch();
        return;
      end
      m_hist.push_back(cc);
      m_try_latch();
    end
    m_age++;
    if (m_age == TIMEOUT) m_fault(2'd3);
  endtask

  // One scan tick: rr/cc are active-high row select and lit-column mask.
  task automatic tick(input bit en, input logic [7:0] rr, input logic [7:0] cc);
    @(negedge clk);
    sample_en = en;
    dot_row   = rr ^ {8{ROW_AL}};
    dot_col   = cc ^ {8{COL_AL}};
    m_step(en, rr, cc);
    @(posedge clk);
    #1;
    check("frame", frame, m_frame);
    check("frame_valid", 64'(frame_valid), 64'(m_fv));
    check("row_seen", 64'(row_seen), 64'(m_seen));
    check("scan_err", 64'(scan_err), 64'(m_err));
    check("err_code", 64'(err_code), 64'(m_code));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1; sample_en = 1'b0;
    @(posedge clk);
    #1;
    m_reset();
    check({tag, "_frame"}, frame, 64'h0);
    check({tag, "_frame_valid"}, 64'(frame_valid), 64'h0);
    check({tag, "_row_seen"}, 64'(row_seen), 64'h0);
    check({tag, "_scan_err"}, 64'(scan_err), 64'h0);
    check({tag, "_err_code"}, 64'(err_code), 64'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit          en;
    logic [7:0]  row;
    logic [7:0]  col;
    logic [7:0]  seen;
    bit          fv;
    bit          err;
    logic [1:0]  code;
    logic [63:0] frame;
  } vec_t;

  vec_t tbl [$];

  function automatic void add(input bit en, input logic [7:0] row, input logic [7:0] col,
                              input logic [7:0] seen, input bit fv, input bit err,
                              input logic [1:0] code, input logic [63:0] frm);
    vec_t v;
    v.en = en; v.row = row; v.col = col; v.seen = seen;
    v.fv = fv; v.err = err; v.code = code; v.frame = frm;
    tbl.push_back(v);
  endfunction

  localparam logic [63:0] F81 = 64'h8181818181818181;
  localparam logic [63:0] FG  = 64'h8877665544332211;

  int          n_fv;
  int          row_sel, hold;
  logic [7:0]  cols [8];
  logic [7:0]  rv, cv;

  initial begin
    rst = 1'b1; sample_en = 1'b0; dot_row = '0; dot_col = '1;
    m_reset();

    // Clean scan, a gated cycle mid-scan, then an incomplete scan and a multi-row fault.
    add(1, 8'h01, 8'h81, 8'h00, 0, 0, 2'd0, 64'h0);
    add(1, 8'h01, 8'h81, 8'h01, 0, 0, 2'd0, 64'h0);
    add(1, 8'h02, 8'h81, 8'h01, 0, 0, 2'd0, 64'h0);
    add(1, 8'h02, 8'h81, 8'h03, 0, 0, 2'd0, 64'h0);
    add(1, 8'h04, 8'h81, 8'h03, 0, 0, 2'd0, 64'h0);
    add(1, 8'h04, 8'h81, 8'h07, 0, 0, 2'd0, 64'h0);
    add(0, 8'hFF, 8'h00, 8'h07, 0, 0, 2'd0, 64'h0);
    add(1, 8'h08, 8'h81, 8'h07, 0, 0, 2'd0, 64'h0);
    add(1, 8'h08, 8'h81, 8'h0F, 0, 0, 2'd0, 64'h0);
    add(1, 8'h10, 8'h81, 8'h0F, 0, 0, 2'd0, 64'h0);
    add(1, 8'h10, 8'h81, 8'h1F, 0, 0, 2'd0, 64'h0);
    add(1, 8'h20, 8'h81, 8'h1F, 0, 0, 2'd0, 64'h0);
    add(1, 8'h20, 8'h81, 8'h3F, 0, 0, 2'd0, 64'h0);
    add(1, 8'h40, 8'h81, 8'h3F, 0, 0, 2'd0, 64'h0);
    add(1, 8'h40, 8'h81, 8'h7F, 0, 0, 2'd0, 64'h0);
    add(1, 8'h80, 8'h81, 8'h7F, 0, 0, 2'd0, 64'h0);
    add(1, 8'h80, 8'h81, 8'hFF, 0, 0, 2'd0, 64'h0);
    add(1, 8'h01, 8'h81, 8'h00, 1, 0, 2'd0, F81);
    add(1, 8'h01, 8'h42, 8'h00, 0, 0, 2'd0, F81);
    add(1, 8'h01, 8'h42, 8'h01, 0, 0, 2'd0, F81);
    add(1, 8'h02, 8'h42, 8'h01, 0, 0, 2'd0, F81);
    add(1, 8'h02, 8'h42, 8'h03, 0, 0, 2'd0, F81);
    add(1, 8'h04, 8'h42, 8'h03, 0, 0, 2'd0, F81);
    add(1, 8'h04, 8'h42, 8'h07, 0, 0, 2'd0, F81);
    add(1, 8'h08, 8'h42, 8'h07, 0, 0, 2'd0, F81);
    add(1, 8'h08, 8'h42, 8'h0F, 0, 0, 2'd0, F81);
    add(1, 8'h10, 8'h42, 8'h0F, 0, 0, 2'd0, F81);
    add(1, 8'h10, 8'h42, 8'h1F, 0, 0, 2'd0, F81);
    add(1, 8'h20, 8'h42, 8'h1F, 0, 0, 2'd0, F81);
    add(1, 8'h40, 8'h42, 8'h1F, 0, 0, 2'd0, F81);
    add(1, 8'h40, 8'h42, 8'h5F, 0, 0, 2'd0, F81);
    add(1, 8'h80, 8'h42, 8'h5F, 0, 0, 2'd0, F81);
    add(1, 8'h80, 8'h42, 8'hDF, 0, 0, 2'd0, F81);
    add(1, 8'h01, 8'h42, 8'h00, 0, 1, 2'd1, F81);
    add(1, 8'h03, 8'h42, 8'h00, 0, 1, 2'd2, F81);

    repeat (2) @(posedge clk);
    #1;
    check("rst_frame", frame, 64'h0);
    check("rst_frame_valid", 64'(frame_valid), 64'h0);
    check("rst_row_seen", 64'(row_seen), 64'h0);
    check("rst_scan_err", 64'(scan_err), 64'h0);
    check("rst_err_code", 64'(err_code), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      tick(tbl[i].en, tbl[i].row, tbl[i].col);
      check($sformatf("tbl%0d_row_seen", i), 64'(row_seen), 64'(tbl[i].seen));
      check($sformatf("tbl%0d_frame_valid", i), 64'(frame_valid), 64'(tbl[i].fv));
      check($sformatf("tbl%0d_scan_err", i), 64'(scan_err), 64'(tbl[i].err));
      check($sformatf("tbl%0d_err_code", i), 64'(err_code), 64'(tbl[i].code));
      check($sformatf("tbl%0d_frame", i), frame, tbl[i].frame);
    end

    // Blank gaps between rows and a 10-cycle gated stretch mid-row, after the multi-row fault.
    for (int r = 0; r < 8; r++) begin
      tick(1, 8'(1 << r), 8'(8'h11 * (r + 1)));
      tick(1, 8'h00, 8'(r));
      tick(1, 8'(1 << r), 8'(8'h11 * (r + 1)));
      if (r == 3) repeat (10) tick(0, 8'hFF, 8'h00);
      tick(1, 8'h00, 8'hA5);
    end
    tick(1, 8'h01, 8'h11);
    check("gap_frame_valid", 64'(frame_valid), 64'h1);
    check("gap_frame", frame, FG);
    // Blanks alone keep counting toward the stuck timeout.
    repeat (TIMEOUT - 2) tick(1, 8'h00, 8'h00);
    check("blank_pre_timeout", 64'(scan_err), 64'h0);
    tick(1, 8'h00, 8'h00);
    check("blank_timeout_err", 64'(scan_err), 64'h1);
    check("blank_timeout_code", 64'(err_code), 64'h3);

    // Reset mid-frame: partial rows must never be published.
    for (int r = 0; r < 5; r++) repeat (2) tick(1, 8'(1 << r), 8'hFF);
    check("pre_rst_row_seen", 64'(row_seen), 64'h1F);
    do_reset("midrst");
    n_fv = 0;
    for (int r = 5; r < 8; r++) repeat (2) begin
      tick(1, 8'(1 << r), 8'hFF);
      if (frame_valid) n_fv++;
    end
    tick(1, 8'h01, 8'hFF);
    if (frame_valid) n_fv++;
    check("midrst_no_publish", 64'(n_fv), 64'h0);
    check("midrst_frame_held", frame, 64'h0);

    // Stuck row: row 3 held; the fault strobes on its 64th tick.
    do_reset("stuck");
    n_fv = 0;
    for (int r = 0; r < 3; r++) repeat (2) tick(1, 8'(1 << r), 8'h3C);
    for (int k = 0; k < TIMEOUT; k++) begin
      tick(1, 8'h08, 8'h3C);
      if (frame_valid) n_fv++;
      if (k == TIMEOUT - 2) check("stuck_tick63_err", 64'(scan_err), 64'h0);
      if (k == TIMEOUT - 1) begin
        check("stuck_tick64_err", 64'(scan_err), 64'h1);
        check("stuck_tick64_code", 64'(err_code), 64'h3);
        check("stuck_row_seen", 64'(row_seen), 64'h0);
      end
    end
    check("stuck_no_publish", 64'(n_fv), 64'h0);

    // Randomized scans with jitter, blanks, gating, out-of-order rows and faults.
    for (int f = 0; f < 60; f++) begin
      for (int r = 0; r < 8; r++) cols[r] = 8'($urandom);
      for (int r = 0; r < 8; r++) begin
        row_sel = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 7)) : r;
        hold    = $urandom_range(1, 3);
        if ($urandom_range(0, 11) == 0) hold = TIMEOUT + 4;
        for (int h = 0; h < hold; h++) begin
          if ($urandom_range(0, 5) == 0) tick(1, 8'h00, 8'($urandom));
          if ($urandom_range(0, 7) == 0) tick(0, 8'($urandom), 8'($urandom));
          rv = 8'(1 << row_sel);
          if ($urandom_range(0, 60) == 0) rv = rv | 8'(1 << ((row_sel + 1) % 8));
          cv = ($urandom_range(0, 9) == 0) ? 8'($urandom) : cols[row_sel];
          tick(1, rv, cv);
        end
      end
    end
    tick(1, 8'h01, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
